// File: rtl/mdu_pkg.sv
// mult_div_unit shared package: MDOp codes, FSM states, default latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdop_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_md(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == 3'd3) || (op == 3'd4);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Start/Busy handshake and HI/LO read port between E stage and the MDU.
interface mdu_if;
  logic        start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        cancel;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, MDOp, A, B, cancel,
    input  Busy, HI, LO
  );

  modport slave (
    input  start, MDOp, A, B, cancel,
    output Busy, HI, LO
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath on the captured operands.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  mdop_e       op_i,
  output logic [31:0] hi_next_o,
  output logic [31:0] lo_next_o,
  output logic        div_zero_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] bd;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic        b_zero;
  logic        ovf;

  assign b_zero = (b_i == 32'd0);
  // never feed a zero divisor to the dividers; the result is dropped anyway
  assign bd     = b_zero ? 32'd1 : b_i;
  assign ovf    = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  assign prod_s = $signed({{32{a_i[31]}}, a_i})
                * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};
  assign q_s    = $signed(a_i) / $signed(bd);
  assign r_s    = $signed(a_i) % $signed(bd);
  assign q_u    = a_i / bd;
  assign r_u    = a_i % bd;

  always_comb begin
    hi_next_o = 32'd0;
    lo_next_o = 32'd0;
    unique case (op_i)
      MDU_MULT: begin
        hi_next_o = prod_s[63:32];
        lo_next_o = prod_s[31:0];
      end
      MDU_MULTU: begin
        hi_next_o = prod_u[63:32];
        lo_next_o = prod_u[31:0];
      end
      MDU_DIV: begin
        hi_next_o = ovf ? 32'd0 : r_s;
        lo_next_o = ovf ? 32'h8000_0000 : q_s;
      end
      MDU_DIVU: begin
        hi_next_o = r_u;
        lo_next_o = q_u;
      end
      default: ;
    endcase
  end

  assign div_zero_o = is_div(op_i) && b_zero;

endmodule

// File: rtl/mult_div_unit.sv
// Fixed-latency MDU with start/Busy handshake and HI/LO registers.
// Define MDU_CANCEL_EN to let cancel suppress start and mthi/mtlo.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave md
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  mdop_e          op_q, op_d;
  logic [31:0]    a_q, a_d;
  logic [31:0]    b_q, b_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;
  logic [31:0]    hi_nx;
  logic [31:0]    lo_nx;
  logic           dz;
  logic           go_ok;

`ifdef MDU_CANCEL_EN
  assign go_ok = !md.cancel;
`else
  logic unused_cancel;
  assign unused_cancel = md.cancel;
  assign go_ok = 1'b1;
`endif

  mdu_arith u_arith (
    .a_i        (a_q),
    .b_i        (b_q),
    .op_i       (op_q),
    .hi_next_o  (hi_nx),
    .lo_next_o  (lo_nx),
    .div_zero_o (dz)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          md.start && is_md(md.MDOp) && go_ok: begin
            state_d = RUN;
            op_d    = mdop_e'(md.MDOp);
            a_d     = md.A;
            b_d     = md.B;
            cnt_d   = is_div(md.MDOp) ? CW'(DIV_CYCLES)
                                      : CW'(MULT_CYCLES);
          end
          go_ok && (md.MDOp == MDU_MTHI): hi_d = md.A;
          go_ok && (md.MDOp == MDU_MTLO): lo_d = md.A;
          default: ;
        endcase
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!dz) begin
            hi_d = hi_nx;
            lo_d = lo_nx;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.Busy = (state_q == RUN);
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus random traffic vs a model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if u_if ();

  mult_div_unit #(
    .MULT_CYCLES (NM),
    .DIV_CYCLES  (ND)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (u_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // reference arithmetic straight from the operation definitions
  function automatic void ref_op(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 output logic [31:0] hi,
                                 output logic [31:0] lo,
                                 output bit dz);
    longint     p;
    logic [63:0] up;
    int         sa;
    int         sb;
    sa = a;
    sb = b;
    hi = '0;
    lo = '0;
    dz = 1'b0;
    case (op)
      3'd1: begin
        p  = longint'(sa) * longint'(sb);
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd2: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      3'd3: begin
        if (b == 0) dz = 1'b1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'd0;
        end else begin
          lo = sa / sb;
          hi = sa % sb;
        end
      end
      3'd4: begin
        if (b == 0) dz = 1'b1;
        else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // model: a launch at edge e commits at edge e+N; busy while pending
  bit          m_valid = 1'b0;
  bit          m_pend  = 1'b0;
  longint      m_end   = 0;
  longint      ecount  = 0;
  logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
  bit          m_dz;

  always @(posedge clk) begin : model
    longint      e;
    logic [31:0] rh, rl;
    bit          dz, canc;
    e = ecount + 1;
    ecount <= e;
`ifdef MDU_CANCEL_EN
    canc = u_if.cancel;
`else
    canc = 1'b0;
`endif
    if (reset) begin
      m_valid <= 1'b1;
      m_pend  <= 1'b0;
      m_hi    <= '0;
      m_lo    <= '0;
    end else if (m_valid) begin
      if (m_pend) begin
        if (e == m_end) begin
          m_pend <= 1'b0;
          if (!m_dz) begin
            m_hi <= m_rhi;
            m_lo <= m_rlo;
          end
        end
      end else if (u_if.start && u_if.MDOp >= 3'd1 &&
                   u_if.MDOp <= 3'd4 && !canc) begin
        ref_op(u_if.MDOp, u_if.A, u_if.B, rh, rl, dz);
        m_rhi  <= rh;
        m_rlo  <= rl;
        m_dz   <= dz;
        m_pend <= 1'b1;
        m_end  <= e + ((u_if.MDOp >= 3'd3) ? ND : NM);
      end else if (!canc && u_if.MDOp == 3'd5) begin
        m_hi <= u_if.A;
      end else if (!canc && u_if.MDOp == 3'd6) begin
        m_lo <= u_if.A;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_busy", {31'd0, u_if.Busy}, {31'd0, m_pend});
      chk("model_hi", u_if.HI, m_hi);
      chk("model_lo", u_if.LO, m_lo);
    end
  end

  task automatic launch(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic c,
                        output int cnt);
    @(negedge clk);
    u_if.start  = 1'b1;
    u_if.MDOp   = op;
    u_if.A      = a;
    u_if.B      = b;
    u_if.cancel = c;
    @(negedge clk);
    u_if.start  = 1'b0;
    u_if.MDOp   = 3'd0;
    u_if.cancel = 1'b0;
    u_if.A      = $urandom;
    u_if.B      = $urandom;
    cnt = 0;
    while (u_if.Busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    u_if.MDOp = op;
    u_if.A    = a;
    @(negedge clk);
    u_if.MDOp = 3'd0;
  endtask

  int cnt;

  initial begin
    reset       = 1'b1;
    u_if.start  = 1'b0;
    u_if.MDOp   = 3'd0;
    u_if.A      = '0;
    u_if.B      = '0;
    u_if.cancel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, u_if.Busy}, 32'd0);
    chk("rst_hi", u_if.HI, 32'd0);
    chk("rst_lo", u_if.LO, 32'd0);

    launch(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, cnt);
    chk("mult_cycles", cnt, NM);
    chk("mult_hi", u_if.HI, 32'hFFFF_FFFF);
    chk("mult_lo", u_if.LO, 32'hFFFF_FFFA);

    launch(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cnt);
    chk("multu_cycles", cnt, NM);
    chk("multu_hi", u_if.HI, 32'hFFFF_FFFE);
    chk("multu_lo", u_if.LO, 32'h0000_0001);

    launch(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, cnt);
    chk("div_cycles", cnt, ND);
    chk("div_lo", u_if.LO, 32'hFFFF_FFFD);
    chk("div_hi", u_if.HI, 32'hFFFF_FFFF);

    launch(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cnt);
    chk("ovf_lo", u_if.LO, 32'h8000_0000);
    chk("ovf_hi", u_if.HI, 32'd0);

    mt(3'd6, 32'h0000_1234);
    chk("mtlo", u_if.LO, 32'h0000_1234);
    launch(3'd4, 32'd77, 32'd0, 1'b0, cnt);
    chk("dz_cycles", cnt, ND);
    chk("dz_lo", u_if.LO, 32'h0000_1234);
    chk("dz_hi", u_if.HI, 32'd0);

    // reset during the third busy cycle of a mult
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.MDOp  = 3'd1;
    u_if.A     = 32'd3;
    u_if.B     = 32'd4;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.MDOp  = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {31'd0, u_if.Busy}, 32'd0);
    chk("midrst_hi", u_if.HI, 32'd0);
    chk("midrst_lo", u_if.LO, 32'd0);

    // a second start while busy must not restart the divide
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.MDOp  = 3'd4;
    u_if.A     = 32'd100;
    u_if.B     = 32'd7;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.MDOp  = 3'd0;
    cnt = 0;
    for (int i = 0; i < 40 && u_if.Busy === 1'b1; i++) begin
      cnt++;
      u_if.start = (i == 2);
      u_if.MDOp  = (i == 2) ? 3'd1 : 3'd0;
      u_if.A     = 32'd9;
      u_if.B     = 32'd9;
      @(negedge clk);
    end
    u_if.start = 1'b0;
    u_if.MDOp  = 3'd0;
    chk("busy_start_cycles", cnt, ND);
    chk("busy_start_lo", u_if.LO, 32'd14);
    chk("busy_start_hi", u_if.HI, 32'd2);
    @(negedge clk);
    chk("busy_start_idle", {31'd0, u_if.Busy}, 32'd0);

    launch(3'd1, 32'd6, 32'd7, 1'b1, cnt);
`ifdef MDU_CANCEL_EN
    chk("cancel_cycles", cnt, 0);
    chk("cancel_hi", u_if.HI, 32'd2);
    chk("cancel_lo", u_if.LO, 32'd14);
`else
    chk("cancel_cycles", cnt, NM);
    chk("cancel_hi", u_if.HI, 32'd0);
    chk("cancel_lo", u_if.LO, 32'd42);
`endif

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset       = ($urandom_range(0, 149) == 0);
      u_if.start  = ($urandom_range(0, 2) == 0);
      u_if.MDOp   = 3'($urandom_range(0, 6));
      u_if.cancel = ($urandom_range(0, 3) == 0);
      u_if.A      = ($urandom_range(0, 9) == 0) ? 32'h8000_0000
                                                : $urandom;
      case ($urandom_range(0, 9))
        0:       u_if.B = 32'd0;
        1:       u_if.B = 32'hFFFF_FFFF;
        2:       u_if.B = 32'($urandom_range(1, 20));
        default: u_if.B = $urandom;
      endcase
    end
    @(negedge clk);
    reset       = 1'b0;
    u_if.start  = 1'b0;
    u_if.MDOp   = 3'd0;
    u_if.cancel = 1'b0;
    repeat (15) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit in the E stage of the P7 pipeline, and the responder half of the start/Busy stall handshake. It accepts a one-cycle start pulse with an operation code, holds Busy high for the operation's fixed latency, and then commits the 64-bit result to the HI/LO registers. The hazard unit in D observes start and Busy and freezes F/D whenever an mult/div/mfhi/mflo/mthi/mtlo instruction is in D while an operation is pending.

## Interface
Parameters:
- MULT_CYCLES, 5: Busy-high cycles for mult/multu.
- DIV_CYCLES, 10: Busy-high cycles for div/divu.

Ports (reset is synchronous, active-high; the polarity and synchronicity are fixed):
- clk, input, 1: system clock.
- reset, input, 1: synchronous active-high reset.
- start, input, 1: one-cycle launch pulse for mult/multu/div/divu.
- MDOp, input, 3: operation code. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
- A, input, 32: rs operand, already forwarded.
- B, input, 32: rt operand, already forwarded.
- cancel, input, 1: an exception or interrupt was taken in M this cycle. It is honoured only with MDU_CANCEL_EN.
- Busy, output, 1: an operation is in flight.
- HI, output, 32: HI register.
- LO, output, 32: LO register.

## Operation
- Reset values: Busy=0, HI=0, LO=0, counter=0, state IDLE.
- State IDLE. An operation is accepted when start=1 and MDOp is 1–4.
  - Capture A, B and MDOp.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- start with MDOp of 0, 5 or 6 is ignored.
- State RUN.
  - Busy=1 and the counter decrements each cycle.
  - When the counter reaches 1, latch the result into HI/LO and return to IDLE.
- Arithmetic:
  - mult: {HI,LO} is the signed 64-bit product.
  - multu: {HI,LO} is the unsigned 64-bit product.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Operands are taken from the captured copies, never the live inputs.
- Divide by zero (B=0 on div or divu): the full latency is still spent and Busy behaves normally, but HI/LO are left unchanged.
- Signed overflow case: div of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.
- mthi/mtlo: when MDOp is 5 or 6 and the unit is not Busy, HI (or LO) takes A at the next edge. No Busy is raised and start is not required.
- Any of the following while Busy is ignored: start, mthi, mtlo. The hazard unit prevents these; the unit must tolerate them anyway.
- Reset mid-operation wins over everything: the next cycle shows Busy=0 and HI=LO=0, and the pending result is discarded.

## Timing
- start sampled at edge T: Busy=1 during cycles T+1 … T+N (N = latency).
- In cycle T+N+1: Busy=0 and HI/LO show the new result.
- A new start may therefore arrive in cycle T+N+1.
- The hazard unit treats start OR Busy as occupied, so there is no gap in which an mfhi in D could read stale HI/LO.
- mthi/mtlo take effect on the next edge; an mfhi in the following cycle sees the new value.
- HI/LO are plain registers. They change only at a commit edge, an mthi/mtlo edge, or reset.

## Configuration
- MDU_CANCEL_EN defined:
  - start and cancel together in one cycle means the operation is not accepted and no Busy is raised. This covers an E-stage mult whose M-stage predecessor is faulting.
  - mthi/mtlo together with cancel are suppressed.
  - cancel during RUN does not abort: the operation belongs to an older, committed instruction.
- MDU_CANCEL_EN undefined: cancel is ignored entirely and start alone launches.

## Structure
- mdu_pkg holds:
  - MDOp encodings (MDU_NONE … MDU_MTLO).
  - The state typedef (IDLE, RUN).
  - Default latency constants.
- Sub-module mdu_arith: purely combinational. It takes captured A, B and MDOp and returns hi_next/lo_next plus a div_zero flag.
- The top level holds the FSM, counter, operand capture and HI/LO registers.

## Test plan
- Signed multiply: reset, then mult with A=0xFFFFFFFE (−2), B=3 → Busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned multiply: multu with A=B=0xFFFFFFFF → after 5 Busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
- Signed divide: div with A=−7, B=2 → 10 Busy cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero: mtlo A=0x1234, then divu with B=0 → Busy for 10 cycles; LO stays 0x1234 and HI stays 0.
- Reset and ignored starts:
  - Assert reset at the 3rd Busy cycle of a mult → next cycle Busy=0, HI=LO=0.
  - A start asserted while Busy is ignored; the counter is not restarted.
- Cancel (with MDU_CANCEL_EN): start+cancel with mult → Busy stays 0 and HI/LO are unchanged.
- Cancel (without the macro): start+cancel with mult → the multiply runs normally.
